// File: rtl/ps2_rx_fifo_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_rx_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam int FRAME_BITS  = 11;
  localparam int FILTER_DEF  = 8;
  localparam int TIMEOUT_DEF = 24000;

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus run-length filter for one PS/2 line.
// The filtered level only moves after FILTER consecutive equal samples; fall_o is a registered one-cycle strobe.
module ps2_line_filter
  import ps2_rx_fifo_pkg::*;
#(
  parameter int FILTER = FILTER_DEF
) (
  input  logic clkk,
  input  logic reset_n,
  input  logic line_i,
  output logic filt_o,
  output logic fall_o
);

  localparam int CW = $clog2(FILTER + 1);

  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (sync2_q == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(FILTER - 1)) begin
      filt_d = sync2_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    fall_d = filt_q & ~filt_d;
  end

  always_ff @(posedge clkk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_o = filt_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host frame receiver feeding a small byte FIFO with a rden/q/dsr pull interface.
// Frame state advances only on filtered ps2_clk falls; a mid-frame stall of TIMEOUT cycles aborts the frame.
module ps2_rx_fifo
  import ps2_rx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3,
  parameter int FILTER     = FILTER_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  clkk,
  input  logic                  reset_n,
  input  logic                  ps2_clk,
  input  logic                  ps2_dat,
  input  logic                  rden,
  output logic [7:0]            q,
  output logic                  dsr,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  err_parity,
  output logic                  err_frame,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int TW    = $clog2(TIMEOUT + 1);

  logic clk_filt_unused, clk_fall, dat_filt, dat_fall_unused;

  ps2_line_filter #(.FILTER(FILTER)) u_clk_filt (
    .clkk    (clkk),
    .reset_n (reset_n),
    .line_i  (ps2_clk),
    .filt_o  (clk_filt_unused),
    .fall_o  (clk_fall)
  );

  ps2_line_filter #(.FILTER(FILTER)) u_dat_filt (
    .clkk    (clkk),
    .reset_n (reset_n),
    .line_i  (ps2_dat),
    .filt_o  (dat_filt),
    .fall_o  (dat_fall_unused)
  );

  ps2_state_e      state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            par_q, par_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            push_vld_q, push_vld_d;
  logic            err_parity_q, err_parity_d;
  logic            err_frame_q, err_frame_d;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    push_vld_d   = 1'b0;
    err_parity_d = 1'b0;
    err_frame_d  = 1'b0;
    tmo_d        = (state_q == ST_IDLE || clk_fall) ? '0 : tmo_q + 1'b1;

    if (state_q != ST_IDLE && !clk_fall && tmo_q == TW'(TIMEOUT - 1)) begin
      state_d     = ST_IDLE;
      shreg_d     = '0;
      tmo_d       = '0;
      err_frame_d = 1'b1;
    end else if (clk_fall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!dat_filt) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shreg_d   = {dat_filt, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = dat_filt;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          // A low stop bit is reported as a framing error even if parity is also bad.
          if (dat_filt && parity_ok(shreg_q, par_q)) push_vld_d   = 1'b1;
          else if (!dat_filt)                        err_frame_d  = 1'b1;
          else                                       err_parity_d = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [7:0]            q_q, q_d;
  logic                  overflow_q, overflow_d;
  logic                  pop, do_push, full;

  // shreg_q is stable in IDLE, so it still holds the byte in the cycle after the stop bit.
  always_comb begin
    full       = (count_q == CW'(DEPTH));
    pop        = rden && (count_q != '0);
    do_push    = push_vld_q && (!full || pop);
    overflow_d = push_vld_q && full && !pop;
    wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    q_d        = pop ? mem_q[rd_ptr_q] : q_q;
    count_d    = count_q;
    if (do_push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clkk) begin
    if (do_push) mem_q[wr_ptr_q] <= shreg_q;
  end

  always_ff @(posedge clkk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      push_vld_q   <= 1'b0;
      err_parity_q <= 1'b0;
      err_frame_q  <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      q_q          <= 8'h00;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      tmo_q        <= tmo_d;
      push_vld_q   <= push_vld_d;
      err_parity_q <= err_parity_d;
      err_frame_q  <= err_frame_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      q_q          <= q_d;
      overflow_q   <= overflow_d;
    end
  end

  assign q          = q_q;
  assign dsr        = (count_q != '0);
  assign count      = count_q;
  assign err_parity = err_parity_q;
  assign err_frame  = err_frame_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench: PS/2 frames bit-banged at 80 clkk per bit, FIFO drained through rden.
module tb_ps2_rx_fifo;
  import ps2_rx_fifo_pkg::*;

  localparam int TMO = 400;

  logic       clkk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       rden = 1'b0;
  logic [7:0] q;
  logic       dsr;
  logic [3:0] count;
  logic       err_parity, err_frame, overflow;

  int total = 0;
  int bad = 0;
  int n_par = 0;
  int n_frm = 0;
  int n_ovf = 0;

  ps2_rx_fifo #(.DEPTH_LOG2(3), .FILTER(8), .TIMEOUT(TMO)) dut (
    .clkk       (clkk),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .rden       (rden),
    .q          (q),
    .dsr        (dsr),
    .count      (count),
    .err_parity (err_parity),
    .err_frame  (err_frame),
    .overflow   (overflow)
  );

  always #5 clkk = ~clkk;

  always @(negedge clkk) begin
    if (reset_n) begin
      if (err_parity) n_par++;
      if (err_frame)  n_frm++;
      if (overflow)   n_ovf++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic flip_par);
    return {1'b1, (~^b) ^ flip_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clkk) ps2_dat = f[i];
      repeat (20) @(negedge clkk);
      ps2_clk = 1'b0;
      repeat (40) @(negedge clkk);
      ps2_clk = 1'b1;
      repeat (20) @(negedge clkk);
    end
    ps2_dat = 1'b1;
    repeat (30) @(negedge clkk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(make_frame(b, 1'b0), FRAME_BITS);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    @(negedge clkk) rden = 1'b1;
    @(negedge clkk) rden = 1'b0;
    chk(tag, {24'h0, q}, {24'h0, exp});
  endtask

  initial begin
    repeat (3) @(negedge clkk);
    chk("rst_dsr", {31'h0, dsr}, 0);
    chk("rst_count", {28'h0, count}, 0);
    chk("rst_q", {24'h0, q}, 0);
    chk("rst_pulses", {29'h0, err_parity, err_frame, overflow}, 0);
    reset_n = 1'b1;
    repeat (20) @(negedge clkk);

    send_byte(8'h1C);
    chk("t1_dsr", {31'h0, dsr}, 1);
    chk("t1_count", {28'h0, count}, 1);
    pop_chk("t1_q", 8'h1C);
    chk("t1_dsr_after", {31'h0, dsr}, 0);
    chk("t1_count_after", {28'h0, count}, 0);
    pop_chk("empty_pop_q", 8'h1C);
    chk("empty_pop_count", {28'h0, count}, 0);

    send_byte(8'hF0);
    send_byte(8'h1C);
    chk("t2_count", {28'h0, count}, 2);
    pop_chk("t2_q0", 8'hF0);
    pop_chk("t2_q1", 8'h1C);
    chk("t2_no_err", n_par + n_frm + n_ovf, 0);

    send_bits(make_frame(8'h1C, 1'b1), FRAME_BITS);
    chk("t3_err_parity", n_par, 1);
    chk("t3_count", {28'h0, count}, 0);
    send_byte(8'h1C);
    chk("t3_count_good", {28'h0, count}, 1);
    pop_chk("t3_q", 8'h1C);

    for (int i = 1; i <= 9; i++) send_byte(8'h10 + 8'(i));
    chk("t4_count_full", {28'h0, count}, 8);
    chk("t4_overflow", n_ovf, 1);
    for (int i = 1; i <= 8; i++) pop_chk($sformatf("t4_q%0d", i), 8'h10 + 8'(i));
    chk("t4_count_empty", {28'h0, count}, 0);

    send_bits(make_frame(8'h1C, 1'b0), 5);
    repeat (TMO - 100) @(negedge clkk);
    chk("t5_no_early_tmo", n_frm, 0);
    repeat (100) @(negedge clkk);
    chk("t5_err_frame", n_frm, 1);
    send_byte(8'h5A);
    chk("t5_count", {28'h0, count}, 1);
    pop_chk("t5_q", 8'h5A);
    chk("t5_err_parity_total", n_par, 1);

    @(negedge clkk) ps2_clk = 1'b0;
    repeat (2) @(negedge clkk);
    ps2_clk = 1'b1;
    repeat (50) @(negedge clkk);
    chk("t6_glitch_pulses", n_par + n_frm + n_ovf, 3);
    chk("t6_glitch_count", {28'h0, count}, 0);
    send_byte(8'h33);
    pop_chk("t6_after_glitch_q", 8'h33);

    send_byte(8'h21);
    send_byte(8'h22);
    send_byte(8'h23);
    chk("t7_count3", {28'h0, count}, 3);
    send_bits(make_frame(8'h44, 1'b0), 3);
    @(negedge clkk) reset_n = 1'b0;
    #1;
    chk("t7_rst_dsr", {31'h0, dsr}, 0);
    chk("t7_rst_count", {28'h0, count}, 0);
    chk("t7_rst_q", {24'h0, q}, 0);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (20) @(negedge clkk);
    reset_n = 1'b1;
    repeat (20) @(negedge clkk);
    send_byte(8'h1C);
    chk("t7_post_rst_count", {28'h0, count}, 1);
    pop_chk("t7_post_rst_q", 8'h1C);
    chk("final_err_frame", n_frm, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
